// File: rtl/mul_acc.sv
// Group accumulator for the signed multiplier product stream.
// Sums prod_last-framed groups with optional saturation and holds one result behind a valid/ready register.
module mul_acc #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 8,
    parameter bit SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_last,
    output logic              res_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  res,
    output logic [CNT_W-1:0]  res_cnt,
    output logic              res_ovf,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (&c) begin
            r = c;
        end else begin
            r = c + CNT_W'(1'b1);
        end
        return r;
    endfunction

    state_t            state_r, state_s;
    logic [ACC_W-1:0]  acc_r, acc_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              ovf_sticky_r, ovf_sticky_s;
    logic [ACC_W-1:0]  res_r, res_s;
    logic [CNT_W-1:0]  res_cnt_r, res_cnt_s;
    logic              res_ovf_r, res_ovf_s;
    logic              res_valid_r, res_valid_s;

    logic              prod_ready_s;
    logic              beat_s;
    logic              pop_s;
    logic              in_acc_s;
    logic [ACC_W-1:0]  base_s;
    logic [CNT_W-1:0]  cnt_base_s;
    logic              ovf_base_s;
    logic [ACC_W-1:0]  prod_ext_s;
    logic [ACC_W-1:0]  raw_s;
    logic              ovf_s;
    logic [ACC_W-1:0]  sum_s;

    // Handshake decode; ready ignores prod_valid so the producer may look before driving.
    always_comb begin
        prod_ready_s = !clear && (!res_valid_r || out_ready);
        beat_s       = prod_valid && prod_ready_s;
        pop_s        = res_valid_r && out_ready;
        in_acc_s     = (state_r == ST_ACC);
    end

    // Adder with sign-based overflow detection; IDLE starts each group from zero.
    always_comb begin
        base_s     = in_acc_s ? acc_r : {ACC_W{1'b0}};
        cnt_base_s = in_acc_s ? cnt_r : {CNT_W{1'b0}};
        ovf_base_s = in_acc_s ? ovf_sticky_r : 1'b0;
        prod_ext_s = ACC_W'($signed(prod));
        raw_s      = base_s + prod_ext_s;
        ovf_s      = (base_s[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                     (raw_s[ACC_W-1] != base_s[ACC_W-1]);
        if (ovf_s && SAT) begin
            sum_s = base_s[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_s = raw_s;
        end
    end

    // Next-state for group FSM, accumulator and output register.
    always_comb begin
        state_s      = state_r;
        acc_s        = acc_r;
        cnt_s        = cnt_r;
        ovf_sticky_s = ovf_sticky_r;
        res_s        = res_r;
        res_cnt_s    = res_cnt_r;
        res_ovf_s    = res_ovf_r;
        res_valid_s  = res_valid_r;

        if (pop_s) begin
            res_valid_s = 1'b0;
        end else begin
            res_valid_s = res_valid_r;
        end

        if (clear) begin
            // clear blocks prod_ready, so no publish can collide with it
            state_s      = ST_IDLE;
            acc_s        = {ACC_W{1'b0}};
            cnt_s        = {CNT_W{1'b0}};
            ovf_sticky_s = 1'b0;
        end else if (beat_s && prod_last) begin
            res_s        = sum_s;
            res_cnt_s    = sat_inc(cnt_base_s);
            res_ovf_s    = ovf_base_s | ovf_s;
            res_valid_s  = 1'b1;
            state_s      = ST_IDLE;
            acc_s        = {ACC_W{1'b0}};
            cnt_s        = {CNT_W{1'b0}};
            ovf_sticky_s = 1'b0;
        end else if (beat_s) begin
            case (state_r)
                ST_IDLE: begin
                    acc_s        = sum_s;
                    cnt_s        = {{(CNT_W-1){1'b0}}, 1'b1};
                    ovf_sticky_s = ovf_s;
                    state_s      = ST_ACC;
                end
                ST_ACC: begin
                    acc_s        = sum_s;
                    cnt_s        = sat_inc(cnt_r);
                    ovf_sticky_s = ovf_sticky_r | ovf_s;
                    state_s      = ST_ACC;
                end
                default: begin
                    state_s      = ST_IDLE;
                    acc_s        = {ACC_W{1'b0}};
                    cnt_s        = {CNT_W{1'b0}};
                    ovf_sticky_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and result registers; reset input is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r      <= ST_IDLE;
            acc_r        <= {ACC_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            ovf_sticky_r <= 1'b0;
            res_r        <= {ACC_W{1'b0}};
            res_cnt_r    <= {CNT_W{1'b0}};
            res_ovf_r    <= 1'b0;
            res_valid_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            acc_r        <= acc_s;
            cnt_r        <= cnt_s;
            ovf_sticky_r <= ovf_sticky_s;
            res_r        <= res_s;
            res_cnt_r    <= res_cnt_s;
            res_ovf_r    <= res_ovf_s;
            res_valid_r  <= res_valid_s;
        end
    end

    assign prod_ready = prod_ready_s;
    assign res_valid  = res_valid_r;
    assign res        = res_r;
    assign res_cnt    = res_cnt_r;
    assign res_ovf    = res_ovf_r;
    assign busy       = (state_r == ST_ACC);

endmodule

// File: tb/tb_mul_acc.sv
// Directed bench for mul_acc: default 72-bit instance is scoreboarded on every pop,
// two 64-bit instances (saturating and wrapping) share the stimulus for overflow checks.
module tb_mul_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        prod_valid;
    logic [63:0] prod;
    logic        prod_last;
    logic        out_ready;

    logic        prod_ready0, res_valid0, res_ovf0, busy0;
    logic [71:0] res0;
    logic [7:0]  res_cnt0;
    logic        prod_ready1, res_valid1, res_ovf1, busy1;
    logic [63:0] res1;
    logic [7:0]  res_cnt1;
    logic        prod_ready2, res_valid2, res_ovf2, busy2;
    logic [63:0] res2;
    logic [7:0]  res_cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [71:0] res;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mul_acc d0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
        .prod_ready(prod_ready0), .prod(prod), .prod_last(prod_last),
        .res_valid(res_valid0), .out_ready(out_ready), .res(res0),
        .res_cnt(res_cnt0), .res_ovf(res_ovf0), .busy(busy0)
    );

    mul_acc #(.ACC_W(64), .SAT(1'b1)) d1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
        .prod_ready(prod_ready1), .prod(prod), .prod_last(prod_last),
        .res_valid(res_valid1), .out_ready(out_ready), .res(res1),
        .res_cnt(res_cnt1), .res_ovf(res_ovf1), .busy(busy1)
    );

    mul_acc #(.ACC_W(64), .SAT(1'b0)) d2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
        .prod_ready(prod_ready2), .prod(prod), .prod_last(prod_last),
        .res_valid(res_valid2), .out_ready(out_ready), .res(res2),
        .res_cnt(res_cnt2), .res_ovf(res_ovf2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [71:0] r, input logic [7:0] c, input logic o);
        exp_t e;
        e.res = r;
        e.cnt = c;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [63:0] p, input logic l);
        prod_valid = v;
        prod       = p;
        prod_last  = l;
    endtask

    // One clock: at the falling edge compare any result being popped, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (res_valid0 && out_ready) begin
            chk("sb_nonempty", 72'(exp_q.size() != 0), 72'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pop_res", res0, e.res);
                chk("pop_cnt", 72'(res_cnt0), 72'(e.cnt));
                chk("pop_ovf", 72'(res_ovf0), 72'(e.ovf));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        clear = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", 72'(res_valid0), 72'd0);
        chk("rst_busy", 72'(busy0), 72'd0);
        chk("rst_res", res0, 72'd0);
        chk("rst_res_cnt", 72'(res_cnt0), 72'd0);
        chk("rst_res_ovf", 72'(res_ovf0), 72'd0);
        chk("rst_prod_ready", 72'(prod_ready0), 72'd1);
        rst_n = 1'b0;
        tick();

        // basic group 3, 5, -2 with a stray prod_last while invalid
        out_ready = 1'b1;
        drive(1'b1, 64'd3, 1'b0);
        #1 chk("basic_ready", 72'(prod_ready0), 72'd1);
        tick();
        chk("basic_busy1", 72'(busy0), 72'd1);
        drive(1'b0, 64'd0, 1'b1);
        tick();
        chk("stray_last_busy", 72'(busy0), 72'd1);
        chk("stray_last_novalid", 72'(res_valid0), 72'd0);
        drive(1'b1, 64'd5, 1'b0);
        tick();
        chk("basic_busy2", 72'(busy0), 72'd1);
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        push(72'd6, 8'd3, 1'b0);
        #1 chk("basic_not_early", 72'(res_valid0), 72'd0);
        tick();
        chk("basic_valid", 72'(res_valid0), 72'd1);
        chk("basic_idle", 72'(busy0), 72'd0);
        drive(1'b0, 64'd0, 1'b0);
        tick();
        chk("basic_drained", 72'(res_valid0), 72'd0);

        // back-to-back single-beat groups
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        push(72'hFF_FFFF_FFFF_FFFF_FFFF, 8'd1, 1'b0);
        tick();
        chk("b2b_valid1", 72'(res_valid0), 72'd1);
        chk("b2b_res1", res0, 72'hFF_FFFF_FFFF_FFFF_FFFF);
        drive(1'b1, 64'd7, 1'b1);
        push(72'd7, 8'd1, 1'b0);
        tick();
        chk("b2b_valid2", 72'(res_valid0), 72'd1);
        chk("b2b_res2", res0, 72'd7);
        drive(1'b0, 64'd0, 1'b0);
        tick();

        // backpressure holds result and stalls the stream
        out_ready = 1'b0;
        drive(1'b1, 64'd10, 1'b1);
        push(72'd10, 8'd1, 1'b0);
        tick();
        chk("bp_valid", 72'(res_valid0), 72'd1);
        drive(1'b1, 64'd4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_stall", 72'(prod_ready0), 72'd0);
            tick();
            chk("bp_hold_res", res0, 72'd10);
            chk("bp_hold_valid", 72'(res_valid0), 72'd1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release", 72'(prod_ready0), 72'd1);
        push(72'd4, 8'd1, 1'b0);
        tick();
        chk("bp_next_res", res0, 72'd4);
        chk("bp_next_valid", 72'(res_valid0), 72'd1);
        drive(1'b0, 64'd0, 1'b0);
        tick();

        // positive overflow
        drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        tick();
        drive(1'b1, 64'd1, 1'b1);
        push(72'h00_8000_0000_0000_0000, 8'd2, 1'b0);
        tick();
        chk("satp_res", 72'(res1), 72'h7FFF_FFFF_FFFF_FFFF);
        chk("satp_ovf", 72'(res_ovf1), 72'd1);
        chk("satp_cnt", 72'(res_cnt1), 72'd2);
        chk("wrapp_res", 72'(res2), 72'h8000_0000_0000_0000);
        chk("wrapp_ovf", 72'(res_ovf2), 72'd1);
        drive(1'b0, 64'd0, 1'b0);
        tick();

        // negative overflow
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0);
        tick();
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        push(72'hFF_7FFF_FFFF_FFFF_FFFF, 8'd2, 1'b0);
        tick();
        chk("satn_res", 72'(res1), 72'h8000_0000_0000_0000);
        chk("satn_ovf", 72'(res_ovf1), 72'd1);
        chk("wrapn_res", 72'(res2), 72'h7FFF_FFFF_FFFF_FFFF);
        chk("wrapn_ovf", 72'(res_ovf2), 72'd1);
        drive(1'b0, 64'd0, 1'b0);
        tick();

        // overflow flag stays sticky after a later in-range beat
        drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        tick();
        drive(1'b1, 64'd1, 1'b0);
        tick();
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        push(72'h00_7FFF_FFFF_FFFF_FFFF, 8'd3, 1'b0);
        tick();
        chk("sticky_sat_res", 72'(res1), 72'h7FFF_FFFF_FFFF_FFFE);
        chk("sticky_sat_ovf", 72'(res_ovf1), 72'd1);
        chk("sticky_wrap_res", 72'(res2), 72'h7FFF_FFFF_FFFF_FFFF);
        drive(1'b0, 64'd0, 1'b0);
        tick();

        // beat counter saturates while the sum keeps growing
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 64'd1, 1'b0);
            tick();
        end
        drive(1'b1, 64'd1, 1'b1);
        push(72'd301, 8'd255, 1'b0);
        tick();
        chk("cntsat_idle", 72'(busy0), 72'd0);
        drive(1'b0, 64'd0, 1'b0);
        tick();

        // clear leaves a pending result intact
        out_ready = 1'b0;
        drive(1'b1, 64'd11, 1'b1);
        push(72'd11, 8'd1, 1'b0);
        tick();
        drive(1'b0, 64'd0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_keep_res", res0, 72'd11);
        chk("clr_keep_valid", 72'(res_valid0), 72'd1);
        out_ready = 1'b1;
        tick();

        // clear aborts a group mid-way
        drive(1'b1, 64'd100, 1'b0);
        tick();
        drive(1'b1, 64'd200, 1'b0);
        tick();
        chk("clr_busy", 72'(busy0), 72'd1);
        clear = 1'b1;
        drive(1'b1, 64'd50, 1'b0);
        #1 chk("clr_ready", 72'(prod_ready0), 72'd0);
        tick();
        chk("clr_idle", 72'(busy0), 72'd0);
        clear = 1'b0;
        drive(1'b1, 64'd9, 1'b1);
        push(72'd9, 8'd1, 1'b0);
        tick();
        chk("clr_next_res", res0, 72'd9);
        chk("clr_next_cnt", 72'(res_cnt0), 72'd1);
        drive(1'b0, 64'd0, 1'b0);
        tick();

        // async reset while accumulating
        drive(1'b1, 64'd21, 1'b0);
        tick();
        chk("arst_pre_busy", 72'(busy0), 72'd1);
        drive(1'b0, 64'd0, 1'b0);
        #2 rst_n = 1'b1;
        #1 chk("arst_busy", 72'(busy0), 72'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b0;
        #1 chk("arst_ready", 72'(prod_ready0), 72'd1);

        // async reset discards a pending result
        out_ready = 1'b0;
        drive(1'b1, 64'd33, 1'b1);
        push(72'd33, 8'd1, 1'b0);
        tick();
        chk("arst2_pre_valid", 72'(res_valid0), 72'd1);
        drive(1'b0, 64'd0, 1'b0);
        #2 rst_n = 1'b1;
        #1 chk("arst2_valid", 72'(res_valid0), 72'd0);
        chk("arst2_res", res0, 72'd0);
        chk("arst2_cnt", 72'(res_cnt0), 72'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b0;
        #1 chk("arst2_ready", 72'(prod_ready0), 72'd1);

        // normal operation after reset
        out_ready = 1'b1;
        drive(1'b1, 64'd2, 1'b0);
        tick();
        drive(1'b1, 64'd3, 1'b1);
        push(72'd5, 8'd2, 1'b0);
        tick();
        drive(1'b0, 64'd0, 1'b0);
        tick();
        tick();

        chk("sb_drained", 72'(exp_q.size()), 72'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_acc.md
Name: mul_acc

Overview:
- Downstream consumer of the 32x32 signed multiplier's 64-bit product stream.
- Accumulates products into a wide signed accumulator over groups framed by prod_last.
- Optionally saturates on overflow.
- Presents each group result through a single-entry valid/ready output register, and backpressures the multiplier while a result is pending.

Parameters:
- PROD_W, 64: product width from multiplier.
- ACC_W, 72: accumulator/result width. Constraint: ACC_W >= PROD_W.
- CNT_W, 8: beat counter width.
- SAT, 1: 1 = saturate on signed overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-high (1 = reset asserted).
- clear  input  1  synchronous abort of the in-progress group.
- prod_valid  input  1  product beat valid.
- prod_ready  output  1  block accepts a beat this cycle.
- prod  input  PROD_W  signed product.
- prod_last  input  1  beat closes the current group.
- res_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer accepts the result.
- res  output  ACC_W  signed group sum.
- res_cnt  output  CNT_W  beats in the group; saturates at 2^CNT_W-1.
- res_ovf  output  1  an overflow occurred in this group.
- busy  output  1  state == ACC.

Behaviour:
- Reset: state=IDLE; acc, cnt, ovf_sticky, res, res_cnt, res_ovf, res_valid all 0. Reset asserted mid-group discards everything, including a pending result.
- prod_ready = !clear && (!res_valid || out_ready). This is combinational and independent of prod_valid.
- beat = prod_valid && prod_ready.
- sum computation:
  - sum = base + sext(prod, ACC_W), with base = 0 in IDLE and acc in ACC.
  - Overflow: operands share a sign and sum's sign differs.
  - SAT=1 on overflow: sum is clamped to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow), and ovf is flagged.
  - SAT=0 on overflow: sum wraps; ovf is still flagged.
- State IDLE (no beats in group):
  - beat && !prod_last → acc=sum, cnt=1, ovf_sticky=ovf, go to ACC.
  - beat && prod_last → single-beat group; publish (below), stay IDLE.
- State ACC:
  - beat && !prod_last → acc=sum, cnt=sat_inc(cnt), ovf_sticky|=ovf.
  - beat && prod_last → publish, then acc=0, cnt=0, ovf_sticky=0, go to IDLE.
- Publish (registered, next edge):
  - res=sum, res_cnt=sat_inc(cnt_base), res_ovf=ovf_sticky_base|ovf, res_valid=1.
  - cnt_base and ovf_sticky_base are 0 in IDLE.
  - Latency: res_valid rises the cycle after the last beat is accepted.
- Output handshake:
  - res_valid && out_ready → pop.
  - If a publish and a pop occur in the same cycle, the new result replaces the old one and res_valid stays 1 (full throughput, one group per beat).
  - res, res_cnt and res_ovf stay stable while res_valid && !out_ready.
- clear has priority: prod_ready is 0 that cycle, so no beat is taken. acc=0, cnt=0, ovf_sticky=0, state=IDLE. The pending result register and res_valid are unaffected. A pop can still occur in the same cycle.
- res_valid=1 && out_ready=0 → prod_ready=0. The whole stream stalls, including non-last beats, and the accumulator holds.
- cnt saturates at all-ones. Further beats still accumulate.
- prod_last with prod_valid=0 is ignored.

Test Plan:
- Basic group: beats 3, 5, -2 (last on -2), out_ready=1 → res_valid one cycle after the last beat; res=6, res_cnt=3, res_ovf=0; busy=1 during the first two beats' aftermath.
- Single-beat groups back-to-back: prod = 64'hFFFF_FFFF_FFFF_FFFF (i.e. -1) with last, then 7 with last, out_ready=1 → res=-1 (72'hFF_FFFF_FFFF_FFFF_FFFF), cnt=1; next cycle res=7, cnt=1; res_valid continuously 1.
- Backpressure: a group with sum 10 published while out_ready=0; offer the next group's beat 4 → prod_ready=0, res held at 10 for 5 cycles. Raise out_ready → beat 4 accepted the same cycle.
- Saturation, ACC_W=64, SAT=1: beats 64'h7FFF_FFFF_FFFF_FFFF, then 1 (last) → res=64'h7FFF_FFFF_FFFF_FFFF, res_ovf=1.
- Same stimulus with SAT=0 → res=64'h8000_0000_0000_0000, res_ovf=1.
- Clear mid-group: beats 100, 200, then clear=1 with prod_valid=1 and prod=50 → prod_ready=0 that cycle; next group 9 (last) → res=9, res_cnt=1. A previously pending result survives the clear.
- Async reset: assert rst_n between clock edges while in ACC with res_valid=1 → res_valid, busy and res go 0 immediately; prod_ready=1 after release.
